cruise_speed_regulator: RTL and testbench
=========================================

// Module: cruise_speed_regulator
// PURPOSE
//  Closed-loop consumer of the 1-bit magnitude comparator's G/Eq/L flags (actual vs target speed).
//  Gates the comparator via cmp_enable and filters the flags for stability.
//  Issues single-cycle accel/decel step pulses to the throttle path until Eq holds, then reports lock.
//  Sits between the comparator and the throttle actuator; brake and cruise_on come from the driver panel.
// PARAMETERS
//  SETTLE_CYCLES  4    consecutive identical valid flag samples required before acting (>=1)
//  STEP_PERIOD    8    cycles spent in ADJUST before a step pulse is issued (>=1)
//  MAX_STEPS      32   step pulses allowed without reaching lock before fault (>=1)
//  CNT_W          8    width of the internal counters; must hold max(SETTLE_CYCLES,STEP_PERIOD,MAX_STEPS)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  asynchronous active-high reset
//  cruise_on   in   1  driver cruise request, level
//  brake       in   1  brake pedal, level; highest priority
//  cmp_G       in   1  comparator: actual > target
//  cmp_Eq      in   1  comparator: actual == target
//  cmp_L       in   1  comparator: actual < target
//  cmp_enable  out  1  enable to comparator; 1 in SETTLE/ADJUST/LOCKED
//  accel       out  1  one-cycle step-up pulse
//  decel       out  1  one-cycle step-down pulse
//  locked      out  1  high while in LOCKED
//  fault       out  1  sticky: lock not reached within MAX_STEPS
//  state       out  2  OFF=00, SETTLE=01, ADJUST=10, LOCKED=11
// BEHAVIOUR
//  - Reset (async, rst=1): state=OFF; all outputs 0; all counters 0; stored flag vector 0.
//  - All outputs registered; decisions use inputs sampled at the rising edge.
//  - Valid flags: exactly one of {G,Eq,L} high. Zero or multiple high = invalid; the settle counter clears.
//  - Abort: brake=1 or cruise_on=0 in any state -> OFF next edge; no accel/decel pulse on that edge.
//  - Fault clear: cruise_on=0 clears fault. Fault=1 blocks leaving OFF.
//  - OFF: cmp_enable=0. cruise_on=1 & brake=0 & fault=0 -> SETTLE; step count clears.
//  - SETTLE: counts consecutive samples equal to the previous sample and valid; the first sample counts 1.
//    At count==SETTLE_CYCLES: Eq -> LOCKED; G or L -> ADJUST. The step timer clears on entry to ADJUST.
//  - ADJUST: step timer increments each cycle; at timer==STEP_PERIOD-1, sample the flags:
//      L -> accel=1 for 1 cycle; G -> decel=1 for 1 cycle; step count +1; -> SETTLE.
//      Eq -> LOCKED, no pulse. Invalid -> SETTLE, no pulse, step count unchanged.
//  - Step limit: a pulse that brings step count to MAX_STEPS sets fault; state -> OFF on the next edge.
//  - accel and decel are never high together; each pulse is exactly 1 cycle wide.
//  - LOCKED: locked=1; step count clears. Non-Eq valid flags for SETTLE_CYCLES consecutive cycles -> SETTLE.
//    Invalid samples and Eq samples reset that count.
//  - Counters saturate; they never wrap.
//  - Latency with stable L input: cruise_on rise -> first accel = 1 + SETTLE_CYCLES + STEP_PERIOD edges.
//  - Re-entry from OFF always restarts at SETTLE with counters cleared.
// TESTING
//  1. Reset mid-ADJUST (rst pulse) -> state=00 and all outputs 0 immediately, with no clock edge.
//  2. cruise_on=1, L held, defaults -> accel pulse at edge 13, then every 12 edges; decel stays 0.
//  3. L for 2 steps, then Eq -> 2 accel pulses, then locked=1 after 4 Eq cycles; state=11.
//  4. LOCKED, G for 3 cycles then Eq -> stays LOCKED. G for 4 cycles -> SETTLE, then decel pulses.
//  5. G held forever -> fault=1 after the 32nd decel, state=00. Stays OFF with cruise_on=1.
//     cruise_on=0 clears fault.
//  6. brake=1 on the edge a pulse is due -> no pulse, state=00. G&L both high -> never leaves SETTLE.

Source files
------------

// File: rtl/cruise_speed_regulator.sv
// rtl/cruise_speed_regulator.sv - closed-loop speed regulator driven by comparator G/Eq/L flags
// Filters the flags for stability, issues single-cycle accel/decel steps, reports lock or fault.
module cruise_speed_regulator #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STEP_PERIOD   = 8,
  parameter int MAX_STEPS     = 32,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cruise_on,
  input  logic       brake,
  input  logic       cmp_G,
  input  logic       cmp_Eq,
  input  logic       cmp_L,
  output logic       cmp_enable,
  output logic       accel,
  output logic       decel,
  output logic       locked,
  output logic       fault,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_SETTLE = 2'b01,
    S_ADJUST = 2'b10,
    S_LOCKED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_N  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_PERIOD - 1);
  localparam logic [CNT_W-1:0] STEP_MAX  = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_ONE;
  endfunction

  state_t           state_q;
  logic             cmp_enable_q;
  logic             accel_q;
  logic             decel_q;
  logic             locked_q;
  logic             fault_q;
  logic [CNT_W-1:0] settle_cnt_q;
  logic [CNT_W-1:0] step_tmr_q;
  logic [CNT_W-1:0] step_cnt_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [2:0]       prev_flags_q;

  logic [2:0]       flags;
  logic             flag_valid;
  logic             flag_eq;
  logic             flag_up;
  logic             flag_down;
  logic [CNT_W-1:0] settle_d;
  logic [CNT_W-1:0] lock_d;
  logic [CNT_W-1:0] step_d;

  assign flags      = {cmp_G, cmp_Eq, cmp_L};
  assign flag_valid = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign flag_eq    = (flags == 3'b010);
  assign flag_up    = (flags == 3'b001);
  assign flag_down  = (flags == 3'b100);

  // A fresh valid sample restarts the run at 1; only repeats of the stored sample extend it.
  always_comb begin
    settle_d = '0;
    if (flag_valid) begin
      if ((settle_cnt_q == '0) || (flags == prev_flags_q)) begin
        settle_d = sat_inc(settle_cnt_q);
      end else begin
        settle_d = CNT_ONE;
      end
    end
    lock_d = (flag_valid && !flag_eq) ? sat_inc(lock_cnt_q) : '0;
    step_d = sat_inc(step_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_OFF;
      cmp_enable_q <= 1'b0;
      accel_q      <= 1'b0;
      decel_q      <= 1'b0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      settle_cnt_q <= '0;
      step_tmr_q   <= '0;
      step_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      prev_flags_q <= '0;
    end else begin
      accel_q <= 1'b0;
      decel_q <= 1'b0;
      if (!cruise_on) begin
        fault_q <= 1'b0;
      end
      if (brake || !cruise_on) begin
        state_q      <= S_OFF;
        cmp_enable_q <= 1'b0;
        locked_q     <= 1'b0;
        settle_cnt_q <= '0;
        step_tmr_q   <= '0;
        lock_cnt_q   <= '0;
        prev_flags_q <= '0;
      end else begin
        case (state_q)
          S_OFF: begin
            if (!fault_q) begin
              state_q      <= S_SETTLE;
              cmp_enable_q <= 1'b1;
              settle_cnt_q <= '0;
              step_tmr_q   <= '0;
              step_cnt_q   <= '0;
              lock_cnt_q   <= '0;
              prev_flags_q <= '0;
            end
          end
          S_SETTLE: begin
            prev_flags_q <= flags;
            settle_cnt_q <= settle_d;
            if (settle_d >= SETTLE_N) begin
              settle_cnt_q <= '0;
              step_tmr_q   <= '0;
              lock_cnt_q   <= '0;
              if (flag_eq) begin
                state_q    <= S_LOCKED;
                locked_q   <= 1'b1;
                step_cnt_q <= '0;
              end else begin
                state_q <= S_ADJUST;
              end
            end
          end
          S_ADJUST: begin
            if (step_tmr_q >= STEP_LAST) begin
              settle_cnt_q <= '0;
              prev_flags_q <= '0;
              step_tmr_q   <= '0;
              if (flag_eq) begin
                state_q    <= S_LOCKED;
                locked_q   <= 1'b1;
                step_cnt_q <= '0;
                lock_cnt_q <= '0;
              end else if (flag_up || flag_down) begin
                accel_q    <= flag_up;
                decel_q    <= flag_down;
                step_cnt_q <= step_d;
                // The pulse that exhausts the step budget still goes out, but regulation stops.
                if (step_d >= STEP_MAX) begin
                  fault_q      <= 1'b1;
                  state_q      <= S_OFF;
                  cmp_enable_q <= 1'b0;
                end else begin
                  state_q <= S_SETTLE;
                end
              end else begin
                state_q <= S_SETTLE;
              end
            end else begin
              step_tmr_q <= sat_inc(step_tmr_q);
            end
          end
          S_LOCKED: begin
            step_cnt_q <= '0;
            lock_cnt_q <= lock_d;
            if (lock_d >= SETTLE_N) begin
              state_q      <= S_SETTLE;
              locked_q     <= 1'b0;
              lock_cnt_q   <= '0;
              settle_cnt_q <= '0;
              prev_flags_q <= '0;
            end
          end
          default: begin
            state_q      <= S_OFF;
            cmp_enable_q <= 1'b0;
            locked_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmp_enable = cmp_enable_q;
  assign accel      = accel_q;
  assign decel      = decel_q;
  assign locked     = locked_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// tb/tb_cruise_speed_regulator.sv - directed and randomized bench for cruise_speed_regulator
// Reference model tracks the regulator mode and counters with plain integers per clock edge.
module tb_cruise_speed_regulator;

  localparam int SC = 4;
  localparam int SP = 8;
  localparam int MS = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cruise_on = 1'b0;
  logic       brake = 1'b0;
  logic       cmp_G = 1'b0;
  logic       cmp_Eq = 1'b0;
  logic       cmp_L = 1'b0;
  logic       cmp_enable;
  logic       accel;
  logic       decel;
  logic       locked;
  logic       fault;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  int m_state, m_run, m_prev, m_timer, m_steps, m_lrun;
  int m_fault, m_acc, m_dec;

  cruise_speed_regulator dut (
    .clk(clk), .rst(rst), .cruise_on(cruise_on), .brake(brake),
    .cmp_G(cmp_G), .cmp_Eq(cmp_Eq), .cmp_L(cmp_L),
    .cmp_enable(cmp_enable), .accel(accel), .decel(decel),
    .locked(locked), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_prev = 0; m_timer = 0; m_steps = 0; m_lrun = 0;
    m_fault = 0; m_acc = 0; m_dec = 0;
  endtask

  // Flag code: 1=G, 2=Eq, 3=L, 0=not exactly one flag.
  task automatic model_step();
    int code;
    code = 0;
    if ({cmp_G, cmp_Eq, cmp_L} == 3'b100) code = 1;
    else if ({cmp_G, cmp_Eq, cmp_L} == 3'b010) code = 2;
    else if ({cmp_G, cmp_Eq, cmp_L} == 3'b001) code = 3;
    m_acc = 0;
    m_dec = 0;
    if (!cruise_on) m_fault = 0;
    if (brake || !cruise_on) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (m_fault == 0) begin
        m_state = 1; m_run = 0; m_prev = 0; m_steps = 0;
      end
    end else if (m_state == 1) begin
      if (code == 0) m_run = 0;
      else if (m_run > 0 && code != m_prev) m_run = 1;
      else m_run = m_run + 1;
      m_prev = code;
      if (m_run == SC) begin
        m_run = 0; m_timer = 0; m_lrun = 0;
        if (code == 2) begin m_state = 3; m_steps = 0; end
        else m_state = 2;
      end
    end else if (m_state == 2) begin
      if (m_timer < SP - 1) begin
        m_timer = m_timer + 1;
      end else begin
        m_run = 0; m_prev = 0;
        if (code == 2) begin
          m_state = 3; m_steps = 0; m_lrun = 0;
        end else if (code == 0) begin
          m_state = 1;
        end else begin
          if (code == 3) m_acc = 1; else m_dec = 1;
          m_steps = m_steps + 1;
          if (m_steps >= MS) begin m_fault = 1; m_state = 0; end
          else m_state = 1;
        end
      end
    end else begin
      if (code == 1 || code == 3) m_lrun = m_lrun + 1; else m_lrun = 0;
      if (m_lrun == SC) begin m_state = 1; m_run = 0; m_prev = 0; end
    end
  endtask

  task automatic check_model(input string tag);
    logic [6:0] obs, exp;
    obs = {state, cmp_enable, accel, decel, locked, fault};
    exp = {2'(m_state), m_state != 0, m_acc != 0, m_dec != 0, m_state == 3, m_fault != 0};
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("async_reset_outputs");
    chk("async_reset_state", 32'(state), 32'd0);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_flags(input logic g, input logic e, input logic l);
    cmp_G = g; cmp_Eq = e; cmp_L = l;
  endtask

  initial begin
    int acc_edges[$];
    int n_acc, n_dec, guard;
    bit done;
    model_reset();

    // Reset state before and across a clock edge
    #2;
    check_model("reset_no_edge");
    @(posedge clk);
    #1;
    check_model("reset_held_edge");
    rst = 1'b0;

    // Stable L: first accel at edge 13, then every 12 edges
    cruise_on = 1'b1;
    set_flags(0, 0, 1);
    n_dec = 0;
    for (int e = 1; e <= 30; e++) begin
      tick("stable_L");
      if (accel === 1'b1) acc_edges.push_back(e);
      if (decel === 1'b1) n_dec++;
    end
    chk("accel_count_30", 32'(acc_edges.size()), 32'd2);
    if (acc_edges.size() >= 2) begin
      chk("first_accel_edge", 32'(acc_edges[0]), 32'd13);
      chk("second_accel_edge", 32'(acc_edges[1]), 32'd25);
    end
    chk("decel_never", 32'(n_dec), 32'd0);
    chk("mid_adjust_state", 32'(state), 32'd2);
    async_reset();

    // Two accel steps, then Eq -> lock after 4 Eq samples
    n_acc = 0;
    guard = 0;
    while (n_acc < 2 && guard < 60) begin
      tick("L_two_steps");
      if (accel === 1'b1) n_acc++;
      guard++;
    end
    chk("two_accels_seen", 32'(n_acc), 32'd2);
    set_flags(0, 1, 0);
    for (int i = 0; i < 3; i++) tick("eq_settle");
    chk("not_locked_after_3", 32'(locked), 32'd0);
    tick("eq_settle");
    chk("locked_after_4", 32'(locked), 32'd1);
    chk("locked_state", 32'(state), 32'd3);

    // Brief disturbance keeps lock, sustained one drops to SETTLE
    set_flags(1, 0, 0);
    for (int i = 0; i < 3; i++) tick("locked_G3");
    set_flags(0, 1, 0);
    tick("locked_eq");
    tick("locked_eq");
    chk("still_locked", 32'(state), 32'd3);
    set_flags(1, 0, 0);
    for (int i = 0; i < 4; i++) tick("locked_G4");
    chk("unlock_to_settle", 32'(state), 32'd1);
    n_dec = 0;
    guard = 0;
    while (n_dec == 0 && guard < 20) begin
      tick("first_decel");
      if (decel === 1'b1) n_dec++;
      guard++;
    end
    chk("decel_after_unlock", 32'(n_dec), 32'd1);

    // G held until the step budget runs out
    done = 0;
    guard = 0;
    while (!done && guard < 500) begin
      tick("G_forever");
      if (decel === 1'b1) n_dec++;
      if (fault === 1'b1) done = 1;
      guard++;
    end
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_state_off", 32'(state), 32'd0);
    chk("decels_to_fault", 32'(n_dec), 32'(MS));
    for (int i = 0; i < 20; i++) tick("fault_hold");
    chk("fault_blocks_off", 32'(state), 32'd0);
    chk("fault_sticky", 32'(fault), 32'd1);
    cruise_on = 1'b0;
    tick("fault_clear");
    chk("fault_cleared", 32'(fault), 32'd0);

    // Brake on the edge the first accel is due
    cruise_on = 1'b1;
    set_flags(0, 0, 1);
    for (int i = 0; i < 12; i++) tick("pre_brake");
    brake = 1'b1;
    tick("brake_edge");
    chk("brake_no_accel", 32'(accel), 32'd0);
    chk("brake_state_off", 32'(state), 32'd0);
    brake = 1'b0;
    set_flags(1, 0, 1);
    for (int i = 0; i < 40; i++) tick("invalid_GL");
    chk("invalid_stays_settle", 32'(state), 32'd1);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 4) != 0) begin
          case ($urandom_range(0, 2))
            0: set_flags(1, 0, 0);
            1: set_flags(0, 1, 0);
            default: set_flags(0, 0, 1);
          endcase
        end else begin
          set_flags(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      brake = ($urandom_range(0, 99) < 2);
      cruise_on = ($urandom_range(0, 149) != 0);
      tick("random");
      if (accel === 1'b1 && decel === 1'b1) chk("accel_decel_exclusive", 32'd1, 32'd0);
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
